// File: rtl/pixel_compositor.sv
// Per-pixel compositor: registered tile/character ROM addressing, ROM latency
// alignment, priority/transparency resolution and frame-driven animation phases.
module pixel_compositor #(
    parameter int N_CHARS   = 5,
    parameter int ROM_LAT   = 1,
    parameter int COLOR_W   = 8,
    parameter int ANIM_DIV  = 8,
    parameter int BLINK_DIV = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame_start,
    input  logic                   i_valid,
    input  logic [5:0]             i_tile_id,
    input  logic [1:0]             i_item,
    input  logic [5:0]             i_tile_offset,
    input  logic [N_CHARS-1:0]     i_char_hit,
    input  logic [N_CHARS*8-1:0]   i_char_offset,
    input  logic [N_CHARS*4-1:0]   i_char_pose,
    input  logic [N_CHARS-1:0]     i_char_fright,
    output logic [11:0]            o_tile_addr,
    input  logic [3:0]             i_tile_q,
    output logic [12:0]            o_pac_addr,
    input  logic                   i_pac_q,
    output logic [12:0]            o_ghost_addr,
    input  logic [1:0]             i_ghost_q,
    output logic                   o_valid,
    output logic [COLOR_W-1:0]     o_VGA_R,
    output logic [COLOR_W-1:0]     o_VGA_G,
    output logic [COLOR_W-1:0]     o_VGA_B
);
    localparam int WW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_BLUE   = 24'h2121FF;
    localparam logic [23:0] C_PINK   = 24'hFFB8FF;
    localparam logic [23:0] C_PEACH  = 24'hFFB8AE;
    localparam logic [23:0] C_RED    = 24'hFF0000;
    localparam logic [23:0] C_CYAN   = 24'h00FFFF;
    localparam logic [23:0] C_ORANGE = 24'hFFB852;
    localparam logic [23:0] C_YELLOW = 24'hFFFF00;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;

    typedef struct packed {
        logic          v;
        logic          hit;
        logic [WW-1:0] win;
        logic [1:0]    item;
        logic [5:0]    off;
        logic          blink;
        logic          fright;
    } meta_t;

    logic [AW-1:0]      r_anim_cnt;
    logic               r_anim_ph;
    logic [BW-1:0]      r_blink_cnt;
    logic               r_blink_ph;
    logic [11:0]        r_tile_addr;
    logic [12:0]        r_pac_addr;
    logic [12:0]        r_ghost_addr;
    meta_t              r_s1;
    meta_t              r_dl [ROM_LAT];
    logic               r_ov;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    logic          w_hit;
    logic [WW-1:0] w_win;
    logic [7:0]    w_off;
    logic [3:0]    w_pose;
    logic          w_fr;
    logic          w_is_pac;
    logic          w_is_ghost;
    logic [3:0]    w_gpose;
    meta_t         w_s1;
    meta_t         w_m;
    logic [2:0]    w_row;
    logic [2:0]    w_col;
    logic          w_dot;
    logic          w_ener;
    logic [23:0]   w_rgb;

    function automatic logic [COLOR_W-1:0] scale(input logic [7:0] c);
        logic [COLOR_W+7:0] t;
        t = {c, {COLOR_W{1'b0}}};
        return t[COLOR_W+7 -: COLOR_W];
    endfunction

    function automatic logic [23:0] body(input logic [WW-1:0] s);
        case (int'(s))
            2:       return C_PINK;
            3:       return C_CYAN;
            4:       return C_ORANGE;
            default: return C_RED;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_anim_cnt  <= '0;
            r_anim_ph   <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (i_frame_start) begin
            if (r_anim_cnt == AW'(ANIM_DIV - 1)) begin
                r_anim_cnt <= '0;
                r_anim_ph  <= ~r_anim_ph;
            end else begin
                r_anim_cnt <= r_anim_cnt + AW'(1);
            end
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Scan from highest slot down so the lowest hit index wins.
    always_comb begin
        w_hit  = 1'b0;
        w_win  = '0;
        w_off  = '0;
        w_pose = '0;
        w_fr   = 1'b0;
        for (int k = N_CHARS - 1; k >= 0; k--) begin
            if (i_char_hit[k]) begin
                w_hit  = 1'b1;
                w_win  = WW'(k);
                w_off  = i_char_offset[8*k +: 8];
                w_pose = i_char_pose[4*k +: 4];
                w_fr   = (k != 0) && i_char_fright[k];
            end
        end
    end

    assign w_is_pac   = w_hit && (w_win == '0);
    assign w_is_ghost = w_hit && (w_win != '0);
    assign w_gpose    = w_fr ? 4'd12 : w_pose;

    always_comb begin
        w_s1        = '0;
        w_s1.v      = i_valid;
        w_s1.hit    = w_hit;
        w_s1.win    = w_win;
        w_s1.item   = i_item;
        w_s1.off    = i_tile_offset;
        w_s1.blink  = r_blink_ph;
        w_s1.fright = w_fr;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tile_addr  <= '0;
            r_pac_addr   <= '0;
            r_ghost_addr <= '0;
            r_s1         <= '0;
            for (int i = 0; i < ROM_LAT; i++) r_dl[i] <= '0;
        end else begin
            r_tile_addr  <= {i_tile_id, i_tile_offset};
            r_pac_addr   <= w_is_pac ? {w_pose, r_anim_ph, w_off} : 13'd0;
            r_ghost_addr <= w_is_ghost ? {w_gpose, r_anim_ph, w_off} : 13'd0;
            r_s1         <= w_s1;
            r_dl[0]      <= r_s1;
            for (int i = 1; i < ROM_LAT; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    assign o_tile_addr  = r_tile_addr;
    assign o_pac_addr   = r_pac_addr;
    assign o_ghost_addr = r_ghost_addr;

    assign w_m   = r_dl[ROM_LAT-1];
    assign w_row = w_m.off[5:3];
    assign w_col = w_m.off[2:0];
    assign w_dot = (w_m.item == 2'd1)
                && (w_row == 3'd3 || w_row == 3'd4)
                && (w_col == 3'd3 || w_col == 3'd4);
    assign w_ener = (w_m.item == 2'd2) && !w_m.blink
                 && (w_row != 3'd0) && (w_row != 3'd7)
                 && (w_col != 3'd0) && (w_col != 3'd7)
                 && !((w_row == 3'd1 || w_row == 3'd6)
                   && (w_col == 3'd1 || w_col == 3'd6));

    always_comb begin
        w_rgb = C_BLACK;
        if (w_m.hit && (w_m.win == '0) && i_pac_q) begin
            w_rgb = C_YELLOW;
        end else if (w_m.hit && (w_m.win != '0) && (i_ghost_q != 2'd0)) begin
            case (i_ghost_q)
                2'd1:    w_rgb = w_m.fright ? C_BLUE : body(w_m.win);
                2'd2:    w_rgb = C_WHITE;
                default: w_rgb = w_m.fright ? C_PEACH : C_BLUE;
            endcase
        end else if (w_dot || w_ener) begin
            w_rgb = C_PEACH;
        end else begin
            case (i_tile_q)
                4'd1:    w_rgb = C_BLUE;
                4'd2:    w_rgb = C_PINK;
                default: w_rgb = C_BLACK;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ov <= 1'b0;
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
        end else begin
            r_ov <= w_m.v;
            r_r  <= w_m.v ? scale(w_rgb[23:16]) : '0;
            r_g  <= w_m.v ? scale(w_rgb[15:8]) : '0;
            r_b  <= w_m.v ? scale(w_rgb[7:0]) : '0;
        end
    end

    assign o_valid = r_ov;
    assign o_VGA_R = r_r;
    assign o_VGA_G = r_g;
    assign o_VGA_B = r_b;

endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor: two instances (ROM latency 1 and 3) against a
// frame-count based reference model plus directed literal expectations.
module tb_pixel_compositor;
    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_BLUE   = 24'h2121FF;
    localparam logic [23:0] C_PINK   = 24'hFFB8FF;
    localparam logic [23:0] C_PEACH  = 24'hFFB8AE;
    localparam logic [23:0] C_RED    = 24'hFF0000;
    localparam logic [23:0] C_CYAN   = 24'h00FFFF;
    localparam logic [23:0] C_ORANGE = 24'hFFB852;
    localparam logic [23:0] C_YELLOW = 24'hFFFF00;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0;
    logic        valid = 1'b0;
    logic [5:0]  tile_id = '0;
    logic [1:0]  item = '0;
    logic [5:0]  toff = '0;
    logic [4:0]  hit = '0;
    logic [39:0] coff = '0;
    logic [19:0] pose = '0;
    logic [4:0]  fright = '0;

    logic [11:0] ta_a, ta_b;
    logic [12:0] pa_a, pa_b, ga_a, ga_b;
    logic [3:0]  tq_a, tq_b;
    logic        pq_a, pq_b;
    logic [1:0]  gq_a, gq_b;
    logic        ov_a, ov_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic [3:0] tile_rom [4096];
    logic       pac_rom [8192];
    logic [1:0] ghost_rom [8192];

    logic [11:0] tpa = '0;
    logic [12:0] ppa = '0;
    logic [12:0] gpa = '0;
    logic [11:0] tpb [3] = '{default: '0};
    logic [12:0] ppb [3] = '{default: '0};
    logic [12:0] gpb [3] = '{default: '0};

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    int vcnt_a = 0;
    int vcnt_b = 0;
    logic [11:0] cap_ta;
    logic [12:0] cap_pa, cap_ga;

    always #5 clk = ~clk;

    pixel_compositor #(.ROM_LAT(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_valid(valid),
        .i_tile_id(tile_id), .i_item(item), .i_tile_offset(toff),
        .i_char_hit(hit), .i_char_offset(coff), .i_char_pose(pose),
        .i_char_fright(fright),
        .o_tile_addr(ta_a), .i_tile_q(tq_a),
        .o_pac_addr(pa_a), .i_pac_q(pq_a),
        .o_ghost_addr(ga_a), .i_ghost_q(gq_a),
        .o_valid(ov_a), .o_VGA_R(r_a), .o_VGA_G(g_a), .o_VGA_B(b_a)
    );

    pixel_compositor #(.ROM_LAT(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_valid(valid),
        .i_tile_id(tile_id), .i_item(item), .i_tile_offset(toff),
        .i_char_hit(hit), .i_char_offset(coff), .i_char_pose(pose),
        .i_char_fright(fright),
        .o_tile_addr(ta_b), .i_tile_q(tq_b),
        .o_pac_addr(pa_b), .i_pac_q(pq_b),
        .o_ghost_addr(ga_b), .i_ghost_q(gq_b),
        .o_valid(ov_b), .o_VGA_R(r_b), .o_VGA_G(g_b), .o_VGA_B(b_b)
    );

    // Synchronous ROMs: q follows the address by the instance's latency.
    always @(posedge clk) begin
        tpa    <= ta_a;
        ppa    <= pa_a;
        gpa    <= ga_a;
        tpb[0] <= ta_b;
        ppb[0] <= pa_b;
        gpb[0] <= ga_b;
        for (int i = 1; i < 3; i++) begin
            tpb[i] <= tpb[i-1];
            ppb[i] <= ppb[i-1];
            gpb[i] <= gpb[i-1];
        end
    end

    assign tq_a = tile_rom[tpa];
    assign pq_a = pac_rom[ppa];
    assign gq_a = ghost_rom[gpa];
    assign tq_b = tile_rom[tpb[2]];
    assign pq_b = pac_rom[ppb[2]];
    assign gq_b = ghost_rom[gpb[2]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference model: phases come from the total frame count since reset.
    int          frames = 0;
    logic        pv [6] = '{default: 1'b0};
    logic [23:0] prgb [6] = '{default: '0};
    logic        ev = 1'b0;
    logic [11:0] e_ta = '0;
    logic [12:0] e_pa = '0;
    logic [12:0] e_ga = '0;

    always @(posedge clk) begin : model
        int w;
        logic [7:0] off;
        logic [3:0] ps;
        logic fr, ap, bp;
        logic [2:0] row, col;
        logic [23:0] c;
        for (int i = 5; i > 0; i--) begin
            pv[i] = pv[i-1];
            prgb[i] = prgb[i-1];
        end
        ap = ((frames / 8) % 2) == 1;
        bp = ((frames / 16) % 2) == 1;
        w = -1;
        for (int k = 4; k >= 0; k--) if (hit[k]) w = k;
        off = '0; ps = '0; fr = 1'b0;
        if (w >= 0) begin
            off = coff[8*w +: 8];
            ps  = pose[4*w +: 4];
            fr  = fright[w];
        end
        e_ta = {tile_id, toff};
        e_pa = '0;
        e_ga = '0;
        if (w == 0) e_pa = {ps, ap, off};
        if (w > 0) e_ga = {(fr ? 4'd12 : ps), ap, off};
        row = toff[5:3];
        col = toff[2:0];
        if (w == 0 && pac_rom[e_pa]) c = C_YELLOW;
        else if (w > 0 && ghost_rom[e_ga] != 2'd0) begin
            case (ghost_rom[e_ga])
                2'd1: c = fr ? C_BLUE : (w == 2 ? C_PINK : w == 3 ? C_CYAN :
                          w == 4 ? C_ORANGE : C_RED);
                2'd2: c = C_WHITE;
                default: c = fr ? C_PEACH : C_BLUE;
            endcase
        end else if (item == 2'd1 && row inside {3, 4} && col inside {3, 4})
            c = C_PEACH;
        else if (item == 2'd2 && !bp && row inside {[1:6]} && col inside {[1:6]}
                 && !(row inside {1, 6} && col inside {1, 6}))
            c = C_PEACH;
        else if (tile_rom[e_ta] == 4'd1) c = C_BLUE;
        else if (tile_rom[e_ta] == 4'd2) c = C_PINK;
        else c = C_BLACK;
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                pv[i] = 1'b0;
                prgb[i] = '0;
            end
            frames = 0;
            ev = 1'b0;
        end else begin
            pv[0] = valid;
            prgb[0] = valid ? c : '0;
            ev = valid;
            if (fs) frames++;
        end
    end

    always @(negedge clk) begin
        if (ov_a) vcnt_a++;
        if (ov_b) vcnt_b++;
        if (chk_en) begin
            chk("valid_lat1", {31'd0, ov_a}, {31'd0, pv[2]});
            chk("rgb_lat1", {8'd0, r_a, g_a, b_a}, {8'd0, prgb[2]});
            chk("valid_lat3", {31'd0, ov_b}, {31'd0, pv[4]});
            chk("rgb_lat3", {8'd0, r_b, g_b, b_b}, {8'd0, prgb[4]});
            if (ev) begin
                chk("tile_addr", {20'd0, ta_a}, {20'd0, e_ta});
                chk("pac_addr", {19'd0, pa_a}, {19'd0, e_pa});
                chk("ghost_addr", {19'd0, ga_a}, {19'd0, e_ga});
                chk("ghost_addr_lat3", {19'd0, ga_b}, {19'd0, e_ga});
            end
        end
    end

    task automatic send(input logic [5:0] tid, input logic [1:0] it,
                        input logic [5:0] to, input logic [4:0] h,
                        input logic [7:0] off, input logic [3:0] ps,
                        input logic [4:0] fr, input logic f);
        @(posedge clk); #1;
        valid = 1'b1; tile_id = tid; item = it; toff = to; hit = h;
        coff = {5{off}}; pose = {5{ps}}; fright = fr; fs = f;
        @(posedge clk); #1;
        valid = 1'b0; fs = 1'b0; hit = '0; fright = '0; item = '0;
        cap_ta = ta_a;
        cap_pa = pa_a;
        cap_ga = ga_a;
    endtask

    task automatic expect_rgb(input string nm, input logic [23:0] exp);
        int n = 0;
        while (!ov_a && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_valid"}, {31'd0, ov_a}, 32'd1);
        if (ov_a) chk(nm, {8'd0, r_a, g_a, b_a}, {8'd0, exp});
        repeat (6) @(posedge clk);
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; fs = 1'b1;
            @(posedge clk); #1; fs = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, ca, cb, base_a, base_b;
        for (int i = 0; i < 4096; i++) tile_rom[i] = 4'(i % 5);
        for (int i = 0; i < 8192; i++) begin
            pac_rom[i] = (i % 3) == 0;
            ghost_rom[i] = 2'(i % 4);
        end

        repeat (3) @(posedge clk); #1;
        chk("rst_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_rgb", {8'd0, r_a, g_a, b_a}, 32'd0);
        chk("rst_tile_addr", {20'd0, ta_a}, 32'd0);
        chk("rst_ghost_addr", {19'd0, ga_b}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Latency of a single pulse on both instances
        tile_rom[64] = 4'd1;
        @(posedge clk); #1;
        valid = 1'b1; tile_id = 6'd1; toff = '0; hit = '0; item = '0;
        la = 0; lb = 0; ca = 0; cb = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            if (ov_a) begin
                ca++;
                if (la == 0) la = n;
                chk("lat1_rgb", {8'd0, r_a, g_a, b_a}, {8'd0, C_BLUE});
            end
            if (ov_b) begin
                cb++;
                if (lb == 0) lb = n;
            end
        end
        chk("latency_lat1", la, 3);
        chk("latency_lat3", lb, 5);
        chk("pulse_count_lat1", ca, 1);
        chk("pulse_count_lat3", cb, 1);

        // Character priority and colours
        ghost_rom[13'h0625] = 2'd1;
        send(6'd2, 2'd0, 6'd0, 5'b00110, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("p1_ghost_addr", {19'd0, cap_ga}, 32'h625);
        chk("p1_pac_addr", {19'd0, cap_pa}, 32'h0);
        chk("p1_tile_addr", {20'd0, cap_ta}, 32'd128);
        expect_rgb("blinky_over_pinky", C_RED);
        send(6'd2, 2'd0, 6'd0, 5'b00100, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("pinky", C_PINK);
        send(6'd2, 2'd0, 6'd0, 5'b01000, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("inky", C_CYAN);
        send(6'd2, 2'd0, 6'd0, 5'b10000, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("clyde", C_ORANGE);
        ghost_rom[13'h0625] = 2'd2;
        send(6'd2, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("eyes", C_WHITE);
        ghost_rom[13'h0625] = 2'd3;
        send(6'd2, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("pupil", C_BLUE);
        ghost_rom[13'h0625] = 2'd0;
        tile_rom[128] = 4'd2;
        send(6'd2, 2'd0, 6'd0, 5'b00110, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("transparent_to_tile", C_PINK);

        // Frightened ghost
        ghost_rom[13'h1825] = 2'd1;
        send(6'd2, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'b00010, 1'b0);
        chk("fright_addr_hi", {28'd0, cap_ga[12:9]}, 32'd12);
        expect_rgb("fright_body", C_BLUE);
        ghost_rom[13'h1825] = 2'd3;
        send(6'd2, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'b00010, 1'b0);
        expect_rgb("fright_pupil", C_PEACH);

        // Pacman, fright ignored on slot 0
        pac_rom[13'h0625] = 1'b1;
        send(6'd2, 2'd0, 6'd0, 5'b00001, 8'h25, 4'd3, 5'b00001, 1'b0);
        chk("pac_addr", {19'd0, cap_pa}, 32'h625);
        chk("pac_ghost_addr", {19'd0, cap_ga}, 32'h0);
        expect_rgb("pacman", C_YELLOW);
        pac_rom[13'h0625] = 1'b0;
        ghost_rom[13'h0625] = 2'd1;
        tile_rom[320] = 4'd1;
        send(6'd5, 2'd0, 6'd0, 5'b00011, 8'h25, 4'd3, 5'd0, 1'b0);
        expect_rgb("pac_transparent", C_BLUE);

        // Dot and energizer geometry
        tile_rom[192] = 4'd2;
        tile_rom[201] = 4'd1;
        tile_rom[220] = 4'd3;
        send(6'd3, 2'd1, 6'h1C, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("dot_center", C_PEACH);
        send(6'd3, 2'd1, 6'h00, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("dot_edge_tile", C_PINK);
        send(6'd3, 2'd2, 6'h12, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("energizer", C_PEACH);
        send(6'd3, 2'd2, 6'h09, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("energizer_corner", C_BLUE);
        send(6'd3, 2'd3, 6'h1C, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("item_reserved", C_BLACK);

        // Animation phase
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("anim_f0", {31'd0, cap_ga[8]}, 32'd0);
        frame_pulses(7);
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("anim_f7", {31'd0, cap_ga[8]}, 32'd0);
        frame_pulses(1);
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("anim_f8", {31'd0, cap_ga[8]}, 32'd1);
        frame_pulses(7);
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b1);
        chk("anim_same_cycle_old", {31'd0, cap_ga[8]}, 32'd1);
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("anim_f16", {31'd0, cap_ga[8]}, 32'd0);
        repeat (6) @(posedge clk);

        // Energizer blink at 16 and 32 frames
        tile_rom[658] = 4'd1;
        send(6'd10, 2'd2, 6'h12, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("blink_f16", C_BLUE);
        frame_pulses(16);
        send(6'd10, 2'd2, 6'h12, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("blink_f32", C_PEACH);
        frame_pulses(24);
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("anim_f56", {31'd0, cap_ga[8]}, 32'd1);
        repeat (6) @(posedge clk);
        send(6'd10, 2'd2, 6'h12, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("blink_f56", C_BLUE);

        // Reset in the middle of a stream
        base_a = 0; base_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                chk("midrst_valid", {31'd0, ov_a | ov_b}, 32'd0);
                chk("midrst_rgb", {8'd0, r_b, g_b, b_b}, 32'd0);
                base_a = vcnt_a;
                base_b = vcnt_b;
            end
            valid = 1'b1;
            tile_id = 6'($urandom);
            toff = 6'($urandom);
            item = 2'($urandom);
            hit = 5'($urandom);
            coff = {$urandom, 8'($urandom)};
            pose = 20'($urandom);
            if (i == 4) rst = 1'b1;
        end
        @(posedge clk); #1;
        valid = 1'b0; rst = 1'b0; hit = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_late_lat1", vcnt_a - base_a, 0);
        chk("midrst_no_late_lat3", vcnt_b - base_b, 0);
        send(6'd4, 2'd0, 6'd0, 5'b00010, 8'h25, 4'd3, 5'd0, 1'b0);
        chk("anim_after_rst", {31'd0, cap_ga[8]}, 32'd0);
        repeat (6) @(posedge clk);
        send(6'd10, 2'd2, 6'h12, 5'd0, 8'h0, 4'd0, 5'd0, 1'b0);
        expect_rgb("blink_after_rst", C_PEACH);

        // 64 back-to-back mixed pixels
        base_a = vcnt_a;
        base_b = vcnt_b;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            valid = 1'b1;
            tile_id = 6'(i * 7);
            toff = 6'($urandom);
            item = 2'(i % 4);
            hit = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
            coff = {$urandom, 8'($urandom)};
            pose = 20'($urandom);
            fright = 5'($urandom);
            fs = (i % 9) == 0;
        end
        @(posedge clk); #1;
        valid = 1'b0; fs = 1'b0; hit = '0; fright = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_count_lat1", vcnt_a - base_a, 64);
        chk("b2b_count_lat3", vcnt_b - base_b, 64);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
